icache_fetch: RTL and testbench
===============================

# icache_fetch

Direct-mapped, read-only instruction cache between the IF-stage program counter and the backing instruction memory. Returns instruction words combinationally on a hit and raises a stall toward the IF stage and IF/ID register on a miss. On a miss, a refill FSM fetches the whole line over a req/ready handshake. A flush input invalidates all lines, so software-visible instruction updates take effect.

## Interface
- LINES, 16, number of cache lines; power of 2, ≥2
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, ≥2
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  reset; synchronous, active-high
- cpu_req_i  in  1  fetch request (tie high in a free-running pipeline)
- cpu_addr_i  in  32  byte address from PC; bits [1:0] ignored
- cpu_instr_o  out  32  instruction word; valid when cpu_valid_o=1
- cpu_valid_o  out  1  hit this cycle
- cpu_stall_o  out  1  hold PC and IF/ID this cycle
- flush_i  in  1  invalidate all lines
- mem_req_o  out  1  backing-memory read request
- mem_addr_o  out  32  word-aligned refill address
- mem_data_i  in  32  refill data; sampled when mem_req_o and mem_ready_i are both 1
- mem_ready_i  in  1  beat accepted/data valid

## Operation
- Address split: offset = [OFF_W+1:2], index = [IDX_W+OFF_W+1:OFF_W+2], tag = remaining upper bits. OFF_W = log2(WORDS_PER_LINE), IDX_W = log2(LINES).
- Storage: per line, a valid bit, a tag, and WORDS_PER_LINE data words.
- FSM states:
  - IDLE: hit = cpu_req_i & valid[index] & tag match. On a hit, cpu_valid_o=1 and cpu_stall_o=0. On a miss with cpu_req_i=1, cpu_stall_o=1, the line base address is latched, the beat counter is cleared, and the FSM goes to REFILL.
  - REFILL: mem_req_o=1 and mem_addr_o = line base + 4*beat. cpu_stall_o=1 and cpu_valid_o=0. Each handshake writes mem_data_i into word[beat] and increments beat. On the last beat, the tag is written, valid is set, and the FSM goes to IDLE.
- Upstream must hold cpu_addr_i stable while cpu_stall_o=1. The cache uses the latched address regardless.
- cpu_req_i=0 in IDLE: no stall, no valid, no state change.
- flush_i: clears every valid bit at the edge, in any state. A refill in progress continues and validates its line at completion.
- flush_i on the same edge as the final beat: the refilled line ends valid and all others end invalid.
- rst_i: FSM to IDLE, all valid bits cleared, beat counter to 0. Takes priority over flush and over any refill in progress. A reset mid-refill abandons the refill.
- Data/tag arrays are not reset.

## Timing
- Reset values: mem_req_o=0, mem_addr_o=0, cpu_valid_o=0. cpu_stall_o = cpu_req_i (everything is invalid after reset). Perf counters = 0.
- Hit latency: 0 cycles, combinational from cpu_addr_i.
- Miss detected in cycle T (stall=1). REFILL starts at T+1, with mem_req_o registered high.
- With mem_ready_i always 1: beats land in T+1..T+WORDS_PER_LINE, and cycle T+WORDS_PER_LINE+1 hits. That gives 1+WORDS_PER_LINE stall cycles.
- Each ready-low cycle adds one stall cycle.
- mem_req_o and mem_addr_o are registered. They stay stable until the beat is accepted.

## Configuration
- ICACHE_PERF_EN defined: adds outputs perf_hit_o[31:0] and perf_miss_o[31:0].
  - perf_hit_o increments once per IDLE hit cycle.
  - perf_miss_o increments once per IDLE→REFILL transition.
  - Both counters saturate at 0xFFFF_FFFF and are cleared by rst_i (not by flush_i).
- ICACHE_PERF_EN undefined: the ports and counters are absent, with identical behaviour otherwise.

## Structure
- Package icache_pkg holds:
  - the state typedef (IDLE, REFILL);
  - localparam helpers for OFF_W, IDX_W, and TAG_W derived from LINES/WORDS_PER_LINE.
- One sub-module, icache_line_ram, holds the tag/data arrays. It has a combinational read by index and a synchronous word write plus tag write.
- Valid bits, the FSM, the beat counter, and the perf counters live in icache_fetch.

## Test plan
- Cold miss, 0x0000_0040, mem_ready_i=1:
  - stall is high for 5 cycles;
  - mem_addr_o goes 0x40, 0x44, 0x48, 0x4C;
  - the next cycle has cpu_valid_o=1 with the word returned for 0x40.
- Sequential 0x40..0x4C after the fill: four consecutive hits, zero stall.
- Conflict, defaults: 0x40 filled, then 0x440 (same index 4, different tag) → miss and refill at 0x440. A re-access of 0x40 then misses again.
- Wait states: mem_ready_i low 2 cycles, then high for each beat → 13 stall cycles. mem_addr_o is held across the low cycles.
- Flush: fill 0x40, pulse flush_i one cycle, access 0x40 → miss with a full 4-beat refill.
- Reset after 2 beats: mem_req_o=0 the next cycle and the FSM is in IDLE. A retry at the same address does a full 4-beat refill. With ICACHE_PERF_EN, perf counters read 0 after reset and hit=4, miss=1 after the first two scenarios.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  localparam int DEF_LINES          = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Byte address = {tag, index, offset, 2'b00}.
  function automatic int tag_w(input int lines, input int words_per_line);
    return 32 - $clog2(lines) - $clog2(words_per_line) - 2;
  endfunction

  localparam int DEF_OFF_W = off_w(DEF_WORDS_PER_LINE);
  localparam int DEF_IDX_W = idx_w(DEF_LINES);
  localparam int DEF_TAG_W = tag_w(DEF_LINES, DEF_WORDS_PER_LINE);

endpackage

// File: rtl/icache_line_ram.sv
// Tag and data storage for the instruction cache: combinational read by index,
// synchronous single-word write and tag write.
module icache_line_ram
  import icache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int OFF_W         = off_w(WORDS_PER_LINE),
  localparam int IDX_W         = idx_w(LINES),
  localparam int TAG_W         = tag_w(LINES, WORDS_PER_LINE)
) (
  input  logic             clk_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [OFF_W-1:0] rd_off_i,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_word_o,
  input  logic             word_we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [OFF_W-1:0] wr_off_i,
  input  logic [31:0]      wr_word_i,
  input  logic             tag_we_i,
  input  logic [TAG_W-1:0] wr_tag_i
);

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][WORDS_PER_LINE];

  assign rd_tag_o  = tag_mem[rd_idx_i];
  assign rd_word_o = data_mem[rd_idx_i][rd_off_i];

  // NOTE: the arrays have no reset; the valid bits in the controller decide
  // whether their contents mean anything, so clearing them would only cost logic.
  always_ff @(posedge clk_i) begin
    if (word_we_i) begin
      data_mem[wr_idx_i][wr_off_i] <= wr_word_i;
    end
    if (tag_we_i) begin
      tag_mem[wr_idx_i] <= wr_tag_i;
    end
  end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with a line-refill FSM.
// Define ICACHE_PERF_EN to add saturating hit/miss counters (perf_hit_o, perf_miss_o).
module icache_fetch
  import icache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_instr_o,
  output logic        cpu_valid_o,
  output logic        cpu_stall_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ready_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit_o,
  output logic [31:0] perf_miss_o
`endif
);

  localparam int OFF_W  = off_w(WORDS_PER_LINE);
  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(LINES, WORDS_PER_LINE);
  localparam int LINE_W = TAG_W + IDX_W;

  state_e            state_q,    state_d;
  logic [OFF_W-1:0]  beat_q,     beat_d;
  logic [LINE_W-1:0] line_q,     line_d;
  logic              mem_req_q,  mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [LINES-1:0]  valid_q,    valid_d;

  logic [OFF_W-1:0]  cpu_off;
  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [LINE_W-1:0] cpu_line;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_word;
  logic              hit;
  logic              word_we;
  logic              tag_we;
  logic              miss_start;
  logic              unused_addr_bits;

  assign cpu_off  = cpu_addr_i[OFF_W+1:2];
  assign cpu_idx  = cpu_addr_i[IDX_W+OFF_W+1:OFF_W+2];
  assign cpu_tag  = cpu_addr_i[31:IDX_W+OFF_W+2];
  assign cpu_line = cpu_addr_i[31:OFF_W+2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit = (state_q == IDLE) && cpu_req_i && valid_q[cpu_idx] && (rd_tag == cpu_tag);

  icache_line_ram #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_line_ram (
    .clk_i     (clk_i),
    .rd_idx_i  (cpu_idx),
    .rd_off_i  (cpu_off),
    .rd_tag_o  (rd_tag),
    .rd_word_o (rd_word),
    .word_we_i (word_we),
    .wr_idx_i  (line_q[IDX_W-1:0]),
    .wr_off_i  (beat_q),
    .wr_word_i (mem_data_i),
    .tag_we_i  (tag_we),
    .wr_tag_i  (line_q[LINE_W-1:IDX_W])
  );

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    line_d      = line_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    valid_d     = valid_q;
    word_we     = 1'b0;
    tag_we      = 1'b0;
    miss_start  = 1'b0;
    cpu_valid_o = 1'b0;
    cpu_stall_o = 1'b0;

    case (state_q)
      IDLE: begin
        cpu_valid_o = hit;
        cpu_stall_o = cpu_req_i && !hit;
        if (cpu_req_i && !hit) begin
          miss_start = 1'b1;
          state_d    = REFILL;
          line_d     = cpu_line;
          beat_d     = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = {cpu_line, {OFF_W{1'b0}}, 2'b00};
        end
      end
      REFILL: begin
        cpu_stall_o = 1'b1;
        if (mem_ready_i) begin
          word_we    = 1'b1;
          beat_d     = beat_q + OFF_W'(1);
          mem_addr_d = {line_q, beat_q + OFF_W'(1), 2'b00};
          if (&beat_q) begin
            tag_we    = 1'b1;
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The line completing this edge survives a simultaneous flush.
    if (flush_i) begin
      valid_d = '0;
    end
    if (tag_we) begin
      valid_d[line_q[IDX_W-1:0]] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      line_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
    end
  end

  assign cpu_instr_o = rd_word;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_q,  perf_hit_d;
  logic [31:0] perf_miss_q, perf_miss_d;

  always_comb begin
    perf_hit_d  = perf_hit_q;
    perf_miss_d = perf_miss_q;
    if (hit && (perf_hit_q != '1)) begin
      perf_hit_d = perf_hit_q + 32'd1;
    end
    if (miss_start && (perf_miss_q != '1)) begin
      perf_miss_d = perf_miss_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      perf_hit_q  <= perf_hit_d;
      perf_miss_q <= perf_miss_d;
    end
  end

  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed self-checking bench for icache_fetch; backing memory returns {16'hC0DE, addr[15:0]}.
module tb_icache_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_req_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_instr_o;
  logic        cpu_valid_o;
  logic        cpu_stall_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        mem_ready_i;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_o;
  logic [31:0] perf_miss_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  assign mem_data_i = {16'hC0DE, mem_addr_o[15:0]};

  icache_fetch dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_instr_o (cpu_instr_o),
    .cpu_valid_o (cpu_valid_o),
    .cpu_stall_o (cpu_stall_o),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .mem_ready_i (mem_ready_i)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hit_o  (perf_hit_o),
    .perf_miss_o (perf_miss_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Requests addr and runs until the stall drops, with wait_n ready-low cycles before each beat.
  task automatic fill(input string tag, input logic [31:0] addr, input int wait_n,
                      input int exp_stalls);
    int          stalls   = 0;
    int          beats    = 0;
    int          w        = 0;
    int          hold_err = 0;
    logic        prev_low = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] got [4];
    for (int i = 0; i < 4; i++) got[i] = '1;
    cpu_req_i  = 1'b1;
    cpu_addr_i = addr;
    for (int c = 0; c < 200; c++) begin
      mem_ready_i = (w >= wait_n);
      #1;
      if (!cpu_stall_o) break;
      stalls++;
      if (prev_low && (mem_addr_o !== prev_addr)) hold_err++;
      prev_low  = mem_req_o && !mem_ready_i;
      prev_addr = mem_addr_o;
      if (mem_req_o) begin
        if (mem_ready_i) begin
          if (beats < 4) got[beats] = mem_addr_o;
          beats++;
          w = 0;
        end else begin
          w++;
        end
      end
      tick();
    end
    mem_ready_i = 1'b1;
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    check({tag, "_beats"}, 32'(beats), 32'd4);
    for (int i = 0; i < 4; i++) check({tag, "_beat_addr"}, got[i], addr + 32'(4 * i));
    check({tag, "_addr_hold"}, 32'(hold_err), 32'd0);
    check({tag, "_valid_after"}, {31'd0, cpu_valid_o}, 32'd1);
    check({tag, "_instr_after"}, cpu_instr_o, {16'hC0DE, addr[15:0]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_addr_i  = '0;
    flush_i     = 1'b0;
    mem_ready_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_valid", {31'd0, cpu_valid_o}, 32'd0);
    check("rst_stall_noreq", {31'd0, cpu_stall_o}, 32'd0);
`ifdef ICACHE_PERF_EN
    check("rst_perf_hit", perf_hit_o, 32'd0);
    check("rst_perf_miss", perf_miss_o, 32'd0);
`endif
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h40;
    #1;
    check("rst_stall_req", {31'd0, cpu_stall_o}, 32'd1);

    // Cold miss, then four sequential hits on the freshly filled line.
    fill("cold", 32'h40, 0, 5);
    for (int i = 0; i < 4; i++) begin
      cpu_addr_i = 32'h40 + 32'(4 * i);
      #1;
      check("seq_valid", {31'd0, cpu_valid_o}, 32'd1);
      check("seq_stall", {31'd0, cpu_stall_o}, 32'd0);
      check("seq_instr", cpu_instr_o, {16'hC0DE, cpu_addr_i[15:0]});
      tick();
    end
    cpu_req_i = 1'b0;
    #1;
    check("noreq_stall", {31'd0, cpu_stall_o}, 32'd0);
    check("noreq_valid", {31'd0, cpu_valid_o}, 32'd0);
`ifdef ICACHE_PERF_EN
    check("perf_hit_4", perf_hit_o, 32'd4);
    check("perf_miss_1", perf_miss_o, 32'd1);
`endif

    // Conflict on index 4: 0x440 evicts 0x40, which then misses again.
    fill("conflict_440", 32'h440, 0, 5);
    fill("conflict_40", 32'h40, 0, 5);

    // Two ready-low cycles before every beat.
    fill("wait", 32'h80, 2, 13);

    // Flush invalidates everything.
    cpu_addr_i = 32'h40;
    #1;
    check("preflush_hit", {31'd0, cpu_valid_o}, 32'd1);
    cpu_req_i = 1'b0;
    flush_i   = 1'b1;
    tick();
    flush_i    = 1'b0;
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h80;
    #1;
    check("flush_80_stall", {31'd0, cpu_stall_o}, 32'd1);
    check("flush_80_valid", {31'd0, cpu_valid_o}, 32'd0);
    fill("flush_40", 32'h40, 0, 5);

    // Flush on the final-beat edge: refilled line valid, others invalid.
    cpu_addr_i = 32'hC0;
    tick();
    tick();
    tick();
    tick();
    check("fb_last_addr", mem_addr_o, 32'hCC);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    check("fb_c0_valid", {31'd0, cpu_valid_o}, 32'd1);
    check("fb_c0_instr", cpu_instr_o, 32'hC0DE_00C0);
    cpu_addr_i = 32'h40;
    #1;
    check("fb_40_stall", {31'd0, cpu_stall_o}, 32'd1);
    check("fb_40_valid", {31'd0, cpu_valid_o}, 32'd0);

    // Reset after two accepted beats abandons the refill.
    cpu_addr_i = 32'h100;
    tick();
    tick();
    tick();
    check("mid_mem_req", {31'd0, mem_req_o}, 32'd1);
    check("mid_mem_addr", mem_addr_o, 32'h108);
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    #1;
    check("rst2_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst2_mem_addr", mem_addr_o, 32'h0);
    check("rst2_idle_stall", {31'd0, cpu_stall_o}, 32'd0);
`ifdef ICACHE_PERF_EN
    check("rst2_perf_hit", perf_hit_o, 32'd0);
    check("rst2_perf_miss", perf_miss_o, 32'd0);
`endif
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'hC0;
    #1;
    check("rst2_c0_invalid", {31'd0, cpu_valid_o}, 32'd0);
    fill("retry_100", 32'h100, 0, 5);

    cpu_req_i = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
